// File: rtl/img_stream_if.sv
// Memory read port and pixel output stream of img_stream.
// The master side is the streamer; the slave side is the ROM plus the downstream sink.
interface img_stream_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) ();
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] dout;
   logic              dout_vld;
   logic              dout_ready;
   logic              sof;
   logic              eol;
   logic              eof;

   modport master (
      output mem_rd, mem_addr, dout, dout_vld, sof, eol, eof,
      input  mem_din, dout_ready
   );

   modport slave (
      input  mem_rd, mem_addr, dout, dout_vld, sof, eol, eof,
      output mem_din, dout_ready
   );
endinterface

// File: rtl/img_stream.sv
// Streams one frame of pixels from a 1-cycle synchronous ROM with valid/ready output,
// paced to one pixel every INTERVAL cycles, with optional looping and abort.
module img_stream #(
   parameter int DATA_W     = 8,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int NUM_FRAMES = 1,
   parameter int INTERVAL   = 13,
   parameter int ADDR_W     = 10,
   localparam int FS_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            loop_en,
   input  logic [FS_W-1:0] frame_sel,
   img_stream_if.master    bus,
   output logic            busy,
   output logic            done,
   output logic            err
);
   localparam int FRAME_PIX = IMG_W * IMG_H;
   localparam int PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
   localparam int COL_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int GAP_N     = INTERVAL - 3;
   localparam int GAP_W     = (GAP_N > 1) ? $clog2(GAP_N) : 1;

   typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_VLD, S_GAP} state_t;
   localparam state_t S_PACE = (INTERVAL > 3) ? S_GAP : S_RD;

   state_t            r_state, w_nxt;
   logic [PIX_W-1:0]  r_pix, w_pix_nxt;
   logic [COL_W-1:0]  r_col, w_col_nxt;
   logic [ADDR_W-1:0] r_base, w_base_nxt;
   logic [GAP_W-1:0]  r_gap;
   logic              w_acc, w_last, w_sel_ok, w_done_nxt, w_err_nxt;

   logic              r_mem_rd, r_vld, r_sof, r_eol, r_eof, r_done, r_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_dout;

   assign w_acc    = (r_state == S_VLD) && bus.dout_ready;
   assign w_last   = (r_pix == PIX_W'(FRAME_PIX - 1));
   assign w_sel_ok = (32'(frame_sel) < NUM_FRAMES);

   always_comb begin
      w_nxt      = r_state;
      w_pix_nxt  = r_pix;
      w_col_nxt  = r_col;
      w_base_nxt = r_base;
      w_done_nxt = 1'b0;
      w_err_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               if (w_sel_ok) begin
                  w_nxt      = S_RD;
                  w_pix_nxt  = '0;
                  w_col_nxt  = '0;
                  w_base_nxt = ADDR_W'(32'(frame_sel) * FRAME_PIX);
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         S_RD:  w_nxt = S_LAT;
         S_LAT: w_nxt = S_VLD;
         S_VLD: begin
            if (w_acc) begin
               if (w_last) begin
                  w_pix_nxt  = '0;
                  w_col_nxt  = '0;
                  w_done_nxt = 1'b1;
                  w_nxt      = loop_en ? S_PACE : S_IDLE;
               end else begin
                  w_pix_nxt = r_pix + 1'b1;
                  w_col_nxt = (r_col == COL_W'(IMG_W - 1)) ? '0 : r_col + 1'b1;
                  w_nxt     = S_PACE;
               end
            end
         end
         S_GAP:   if (r_gap == '0) w_nxt = S_RD;
         default: w_nxt = S_IDLE;
      endcase
      // Abort overrides everything, including the done of a final beat accepted this cycle.
      if (abort && (r_state != S_IDLE)) begin
         w_nxt      = S_IDLE;
         w_done_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pix   <= '0;
         r_col   <= '0;
         r_base  <= '0;
         r_gap   <= '0;
      end else begin
         r_state <= w_nxt;
         r_pix   <= w_pix_nxt;
         r_col   <= w_col_nxt;
         r_base  <= w_base_nxt;
         if ((w_nxt == S_GAP) && (r_state != S_GAP)) r_gap <= GAP_W'(GAP_N - 1);
         else if (r_state == S_GAP)                  r_gap <= r_gap - 1'b1;
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_rd   <= 1'b0;
         r_mem_addr <= '0;
         r_dout     <= '0;
         r_vld      <= 1'b0;
         r_sof      <= 1'b0;
         r_eol      <= 1'b0;
         r_eof      <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_mem_rd <= (w_nxt == S_RD);
         if (w_nxt == S_RD) r_mem_addr <= w_base_nxt + ADDR_W'(w_pix_nxt);
         if (r_state == S_LAT) r_dout <= bus.mem_din;
         r_vld <= (w_nxt == S_VLD);
         if (w_nxt != S_VLD) begin
            r_sof <= 1'b0;
            r_eol <= 1'b0;
            r_eof <= 1'b0;
         end else if (r_state == S_LAT) begin
            r_sof <= (r_pix == '0);
            r_eol <= (r_col == COL_W'(IMG_W - 1));
            r_eof <= w_last;
         end
         r_done <= w_done_nxt;
         r_err  <= w_err_nxt;
      end
   end

   assign bus.mem_rd   = r_mem_rd;
   assign bus.mem_addr = r_mem_addr;
   assign bus.dout     = r_dout;
   assign bus.dout_vld = r_vld;
   assign bus.sof      = r_sof;
   assign bus.eol      = r_eol;
   assign bus.eof      = r_eof;
   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;
   assign err          = r_err;
endmodule

// File: tb/tb_img_stream.sv
// Scoreboard bench for img_stream: stimulus queues expected beats, a negedge monitor checks them.
module tb_img_stream;
   localparam int DW = 8, IW = 28, IH = 28, NF = 3, IV = 13, AW = 12, FP = IW * IH;

   logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, loop_en = 1'b0;
   logic [1:0] frame_sel = 2'd0;
   logic       busy, done, err;
   logic       rnd_mode = 1'b0, ready_lvl = 1'b1;

   img_stream_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   img_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .NUM_FRAMES(NF),
                .INTERVAL(IV), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
      .frame_sel(frame_sel), .bus(bus), .busy(busy), .done(done), .err(err));

   always #5 clk = ~clk;

   typedef struct packed {logic [7:0] data; logic sof; logic eol; logic eof;} beat_t;
   beat_t exp_q[$];
   int n_cmp = 0, n_bad = 0, cyc = 0, n_xfer = 0, n_done = 0;

   function automatic logic [7:0] rom(input logic [AW-1:0] a);
      logic [15:0] t;
      t = 16'(a) * 16'd37 + 16'd11;
      return t[7:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bus.mem_rd) bus.mem_din <= rom(bus.mem_addr);

   initial begin
      bus.dout_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.dout_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_lvl;
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic push_frame(input int sel, input int first, input int cnt);
      beat_t b;
      for (int p = first; p < first + cnt; p++) begin
         b.data = rom(AW'(sel * FP + p));
         b.sof  = (p == 0);
         b.eol  = ((p % IW) == IW - 1);
         b.eof  = (p == FP - 1);
         exp_q.push_back(b);
      end
   endtask

   // Monitor / scoreboard
   initial begin : mon
      beat_t got, e, prev;
      int start_cyc, last_cyc, eof_cyc, exp_addr;
      bit has_prev, rdy_lo, hold, first_pend, addr_pend, eof_pend;
      has_prev = 0; rdy_lo = 0; hold = 0; first_pend = 0; addr_pend = 0; eof_pend = 0;
      start_cyc = 0; last_cyc = 0; eof_cyc = 0; exp_addr = 0; prev = '0;
      forever begin
         @(negedge clk);
         got = {bus.dout, bus.sof, bus.eol, bus.eof};
         if (rst) begin
            has_prev = 0; hold = 0; first_pend = 0; addr_pend = 0; eof_pend = 0;
         end else begin
            if (addr_pend && bus.mem_rd) begin
               chk("first_addr", int'(bus.mem_addr), exp_addr);
               addr_pend = 0;
            end
            if (first_pend && bus.dout_vld) begin
               chk("first_vld_latency", cyc - start_cyc, 3);
               first_pend = 0;
            end
            if (hold) chk("hold_stable", int'({bus.dout_vld, got}), int'({1'b1, prev}));
            if (eof_pend && (cyc == eof_cyc + 1)) begin
               chk("done_after_eof", int'(done), 1);
               eof_pend = 0;
            end else if (done) begin
               chk("done_unexpected", int'(done), 0);
            end
            if (done) n_done++;
            if (bus.dout_vld && bus.dout_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL beat: got 0x%0h with no beat expected (cycle %0d)", got, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat", int'(got), int'(e));
               end
               if (has_prev && !rdy_lo) chk("beat_spacing", cyc - last_cyc, IV);
               last_cyc = cyc; has_prev = 1; rdy_lo = 0;
               if (got.eof) begin eof_pend = 1; eof_cyc = cyc; end
               n_xfer++;
            end else if (!bus.dout_ready) begin
               rdy_lo = 1;
            end
            hold = bus.dout_vld && !bus.dout_ready && !abort;
            prev = got;
            if (start && !abort && !busy && (int'(frame_sel) < NF)) begin
               first_pend = 1; addr_pend = 1; has_prev = 0;
               start_cyc = cyc; exp_addr = int'(frame_sel) * FP;
            end
         end
      end
   end

   task automatic do_start(input logic [1:0] sel, input logic ab);
      @(posedge clk); #1; start = 1'b1; frame_sel = sel; abort = ab;
      @(posedge clk); #1; start = 1'b0; abort = 1'b0;
   endtask

   task automatic do_abort();
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      chk("abort_idle", int'({busy, bus.dout_vld, bus.mem_rd, bus.sof, bus.eol, bus.eof}), 0);
   endtask

   task automatic wait_xfer(input int n);
      int t = 0;
      while (n_xfer < n && t < 40000) begin @(negedge clk); t++; end
      chk("xfer_wait", int'(n_xfer >= n), 1);
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (n_done < n && t < 40000) begin @(negedge clk); t++; end
      chk("done_wait", int'(n_done >= n), 1);
   endtask

   task automatic wait_vld();
      int t = 0;
      while (!bus.dout_vld && t < 100) begin @(negedge clk); t++; end
      chk("vld_wait", int'(bus.dout_vld), 1);
   endtask

   function automatic int outs();
      return int'({bus.dout, bus.dout_vld, bus.sof, bus.eol, bus.eof, bus.mem_rd,
                   bus.mem_addr, busy, done, err});
   endfunction

   initial begin
      #1 rst = 1'b1;
      #2 chk("reset_outputs", outs(), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Full frame 0, ready high; a start while busy must be ignored
      push_frame(0, 0, FP);
      do_start(2'd0, 1'b0);
      wait_xfer(50);
      do_start(2'd3, 1'b0);
      chk("busy_start_no_err", int'(err), 0);
      chk("busy_held", int'(busy), 1);
      wait_xfer(FP);
      wait_done(1);

      // Full frame 1 with random backpressure
      rnd_mode = 1'b1;
      push_frame(1, 0, FP);
      do_start(2'd1, 1'b0);
      wait_xfer(2 * FP);
      rnd_mode = 1'b0;
      wait_done(2);

      // Frame 2, abort while pixel 100 is pending, then restart from pixel 0
      push_frame(2, 0, 100);
      do_start(2'd2, 1'b0);
      wait_xfer(2 * FP + 100);
      ready_lvl = 1'b0;
      wait_vld();
      do_abort();
      ready_lvl = 1'b1;
      push_frame(2, 0, 5);
      do_start(2'd2, 1'b0);
      wait_xfer(2 * FP + 105);
      do_abort();
      repeat (3) @(negedge clk);
      chk("abort_no_done", n_done, 2);

      // Out-of-range frame and abort-wins cases
      do_start(2'd3, 1'b0);
      chk("err_pulse", int'(err), 1);
      chk("err_busy", int'(busy), 0);
      @(posedge clk); #1;
      chk("err_one_cycle", int'(err), 0);
      do_start(2'd3, 1'b1);
      chk("abort_start_no_err", int'(err), 0);
      do_start(2'd0, 1'b1);
      chk("abort_start_idle", int'(busy), 0);

      // Loop frame 0 three times
      loop_en = 1'b1;
      push_frame(0, 0, FP); push_frame(0, 0, FP); push_frame(0, 0, FP);
      do_start(2'd0, 1'b0);
      wait_done(4);
      loop_en = 1'b0;
      wait_done(5);
      repeat (5) @(negedge clk);
      chk("loop_end_idle", int'(busy), 0);
      chk("loop_done_count", n_done, 5);

      // Reset while in the inter-pixel gap, then stream again
      push_frame(0, 0, 3);
      do_start(2'd0, 1'b0);
      wait_xfer(5 * FP + 108);
      #1 rst = 1'b1;
      #1 chk("mid_gap_reset", outs(), 0);
      @(posedge clk); #1 rst = 1'b0;
      push_frame(1, 0, 4);
      do_start(2'd1, 1'b0);
      wait_xfer(5 * FP + 112);
      do_abort();

      repeat (5) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("final_done_count", n_done, 5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
